// File: rtl/reg_access_ctrl_if.sv
// Request/response handshake plus register-bank drive signals for reg_access_ctrl.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; the source holds its payload stable until then.
interface reg_access_ctrl_if #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int A = 3
) ();
  logic           req_valid;
  logic           req_ready;
  logic           req_wr;
  logic [A-1:0]   req_addr;
  logic [W-1:0]   req_wdata;
  logic [N-1:0]   chosen;
  logic           w_en;
  logic [W-1:0]   w_data;
  logic [N*W-1:0] r_data_all;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic           resp_err;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, r_data_all, resp_ready,
    output req_ready, chosen, w_en, w_data, resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, r_data_all, resp_ready,
    input  req_ready, chosen, w_en, w_data, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Sequenced access controller for a bank of N registers: writes are read back
// and compared, reads capture the selected register, out-of-range addresses error out.
module reg_access_ctrl #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_access_ctrl_if.slave     bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    CHECK = 3'd2,
    READ  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t         state;
  logic [A-1:0]   addr_q;
  logic [W-1:0]   wdata_q;
  logic [W-1:0]   sel_data;
  logic           addr_oor;

  assign dbg_state = state;
  assign addr_oor  = (int'(bus.req_addr) >= N);

  function automatic logic [N-1:0] onehot(input logic [A-1:0] a);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (a == A'(i));
    return v;
  endfunction

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (addr_q == A'(i)) sel_data = bus.r_data_all[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.chosen     <= '0;
      bus.w_en       <= 1'b0;
      bus.w_data     <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (addr_oor) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= '0;
              state          <= RESP;
            end else if (bus.req_wr) begin
              bus.chosen <= onehot(bus.req_addr);
              bus.w_en   <= 1'b1;
              bus.w_data <= bus.req_wdata;
              state      <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          bus.chosen <= '0;
          bus.w_en   <= 1'b0;
          bus.w_data <= '0;
          state      <= CHECK;
        end
        CHECK: begin
          // Written as if/else so an X/Z readback falls to the mismatch branch.
          bus.resp_data <= sel_data;
          if (sel_data == wdata_q) bus.resp_err <= 1'b0;
          else                     bus.resp_err <= 1'b1;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        READ: begin
          bus.resp_data  <= sel_data;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          bus.chosen     <= '0;
          bus.w_en       <= 1'b0;
          bus.w_data     <= '0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
